window_3x3: RTL and testbench

WINDOW_3X3 -- requirements
Module: window_3x3

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/line_buffer.sv | 31 +++
 rtl/window_3x3.sv | 148 ++++++++++++++
 tb/tb_window_3x3.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the 3x3 window generator.
//   PX_SIZE_DEF  : default pixel width in bits
//   CNT_W        : width of the row/column counters
//   WIN_TL..WIN_BR : flat window slot indices, 3*row + col (row 0 = oldest line)
package sobel_pkg;

    localparam int unsigned PX_SIZE_DEF = 8;
    localparam int unsigned CNT_W       = 12;

    localparam int unsigned WIN_TL = 0;
    localparam int unsigned WIN_TC = 1;
    localparam int unsigned WIN_TR = 2;
    localparam int unsigned WIN_ML = 3;
    localparam int unsigned WIN_MC = 4;
    localparam int unsigned WIN_MR = 5;
    localparam int unsigned WIN_BL = 6;
    localparam int unsigned WIN_BC = 7;
    localparam int unsigned WIN_BR = 8;

endpackage

// File: rtl/line_buffer.sv
// Single-line pixel store: asynchronous read, synchronous write.
// A read and a write to the same address in one cycle returns the old entry.
// Contents are not reset.
//   clk     : write clock
//   i_we    : write enable
//   i_addr  : shared read/write address
//   i_wdata : pixel written at i_addr
//   o_rdata : current entry at i_addr
module line_buffer #(
    parameter int unsigned DEPTH  = 1531,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/window_3x3.sv
// 3x3 sliding window over a raster-order pixel stream.
// Optional build macro WINDOW_ZERO_PAD_EN: emit a window for every pixel and
// zero the positions that fall above or left of the image; otherwise only
// windows fully inside the image are emitted.
//   clk, resetn       : clock, asynchronous active-low reset
//   input_data        : incoming pixel
//   input_data_valid  : pixel accepted this cycle
//   window_data       : 3x3 window, slot 3*row+col, row 0 = oldest line
//   window_valid      : one-cycle pulse per emitted window
//   frame_end         : pulses with the window of the last pixel of a frame
module window_3x3
    import sobel_pkg::*;
#(
    parameter int unsigned PX_SIZE      = PX_SIZE_DEF,
    parameter int unsigned IMAGE_WIDTH  = 1531,
    parameter int unsigned IMAGE_HEIGHT = 1080
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [PX_SIZE-1:0]   input_data,
    input  logic                 input_data_valid,
    output logic [9*PX_SIZE-1:0] window_data,
    output logic                 window_valid,
    output logic                 frame_end
);

    localparam int unsigned LB_AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned WIN_W = 9 * PX_SIZE;

    logic [CNT_W-1:0]   r_col;
    logic [CNT_W-1:0]   r_row;
    logic [PX_SIZE-1:0] r_tap [3][2];
    logic [WIN_W-1:0]   r_window_data;
    logic               r_window_valid;
    logic               r_frame_end;

    logic [LB_AW-1:0]   w_addr;
    logic [PX_SIZE-1:0] w_line0_rd;
    logic [PX_SIZE-1:0] w_line1_rd;
    logic [PX_SIZE-1:0] w_col_in [3];
    logic [PX_SIZE-1:0] w_cell   [3][3];
    logic [WIN_W-1:0]   w_win;
    logic               w_emit;
    logic               w_col_last;
    logic               w_row_last;

    assign w_addr     = LB_AW'(r_col);
    assign w_col_last = (r_col == CNT_W'(IMAGE_WIDTH - 1));
    assign w_row_last = (r_row == CNT_W'(IMAGE_HEIGHT - 1));

    // line0 holds row r-1, line1 holds row r-2; line1 is refilled from line0.
    line_buffer #(
        .DEPTH  (IMAGE_WIDTH),
        .WIDTH  (PX_SIZE),
        .ADDR_W (LB_AW)
    ) u_line0 (
        .clk     (clk),
        .i_we    (input_data_valid),
        .i_addr  (w_addr),
        .i_wdata (input_data),
        .o_rdata (w_line0_rd)
    );

    line_buffer #(
        .DEPTH  (IMAGE_WIDTH),
        .WIDTH  (PX_SIZE),
        .ADDR_W (LB_AW)
    ) u_line1 (
        .clk     (clk),
        .i_we    (input_data_valid),
        .i_addr  (w_addr),
        .i_wdata (w_line0_rd),
        .o_rdata (w_line1_rd)
    );

    // Window after this pixel's shift: two stored columns plus the incoming column.
    always_comb begin
        w_col_in[0] = w_line1_rd;
        w_col_in[1] = w_line0_rd;
        w_col_in[2] = input_data;
        for (int i = 0; i < 3; i++) begin
            w_cell[i][0] = r_tap[i][0];
            w_cell[i][1] = r_tap[i][1];
            w_cell[i][2] = w_col_in[i];
        end
`ifdef WINDOW_ZERO_PAD_EN
        // Zero positions above row 0 or left of col 0; this also hides
        // previous-line and previous-frame pixels.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if ((i == 0 && r_row < CNT_W'(2)) || (i == 1 && r_row == '0) ||
                    (j == 0 && r_col < CNT_W'(2)) || (j == 1 && r_col == '0)) begin
                    w_cell[i][j] = '0;
                end
            end
        end
        w_emit = 1'b1;
`else
        // Only fully populated windows: every tap then belongs to this frame and line.
        w_emit = (r_row >= CNT_W'(2)) && (r_col >= CNT_W'(2));
`endif
    end

    for (genvar k = WIN_TL; k <= WIN_BR; k++) begin : g_pack
        assign w_win[PX_SIZE*k +: PX_SIZE] = w_cell[k/3][k%3];
    end

    // Counters, column taps and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col          <= '0;
            r_row          <= '0;
            r_window_data  <= '0;
            r_window_valid <= 1'b0;
            r_frame_end    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 2; k++) begin
                    r_tap[i][k] <= '0;
                end
            end
        end else begin
            r_window_valid <= 1'b0;
            r_frame_end    <= 1'b0;
            if (input_data_valid) begin
                for (int i = 0; i < 3; i++) begin
                    r_tap[i][0] <= r_tap[i][1];
                    r_tap[i][1] <= w_col_in[i];
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + CNT_W'(1);
                end else begin
                    r_col <= r_col + CNT_W'(1);
                end
                r_window_valid <= w_emit;
                r_frame_end    <= w_col_last && w_row_last;
                if (w_emit) begin
                    r_window_data <= w_win;
                end
            end
        end
    end

    assign window_data  = r_window_data;
    assign window_valid = r_window_valid;
    assign frame_end    = r_frame_end;

endmodule

// File: tb/tb_window_3x3.sv
// Scoreboard bench for window_3x3 with a 4x3 image of 8-bit pixels.
// The driver computes each expected window from a frame store of the pixels
// it has sent and queues it; a negedge monitor pops and compares whenever
// window_valid is seen, and checks hold behaviour in idle cycles.
module tb_window_3x3;

    localparam int W = 4;
    localparam int H = 3;
`ifdef WINDOW_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk              = 1'b0;
    logic        resetn           = 1'b0;
    logic [7:0]  input_data       = '0;
    logic        input_data_valid = 1'b0;
    logic [71:0] window_data;
    logic        window_valid;
    logic        frame_end;

    always #5 clk = ~clk;

    window_3x3 #(
        .PX_SIZE      (8),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .input_data       (input_data),
        .input_data_valid (input_data_valid),
        .window_data      (window_data),
        .window_valid     (window_valid),
        .frame_end        (frame_end)
    );

    typedef struct {
        logic [71:0] data;
        logic        fe;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_e;
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    logic        acc_q     = 1'b0;
    logic [71:0] last_data = '0;
    logic [7:0]  img [H][W];
    int          tb_r      = 0;
    int          tb_c      = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        acc_q <= input_data_valid & resetn;
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one pixel for one cycle; queue its expected window if one is due.
    task automatic send(input logic [7:0] pix, input bit push);
        exp_t e;
        img[tb_r][tb_c] = pix;
        e.data = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int rr;
                int cc;
                rr = tb_r - 2 + i;
                cc = tb_c - 2 + j;
                if (rr >= 0 && cc >= 0) begin
                    e.data[8*(3*i+j) +: 8] = img[rr][cc];
                end
            end
        end
        e.fe  = (tb_r == H - 1) && (tb_c == W - 1);
        e.cyc = cyc + 1;
        if (push && (PAD || (tb_r >= 2 && tb_c >= 2))) begin
            exp_q.push_back(e);
        end
        input_data       = pix;
        input_data_valid = 1'b1;
        if (tb_c == W - 1) begin
            tb_c = 0;
            tb_r = (tb_r == H - 1) ? 0 : tb_r + 1;
        end else begin
            tb_c = tb_c + 1;
        end
        @(posedge clk);
        #1;
        input_data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input bit gaps);
        for (int k = 0; k < W * H; k++) begin
            send(base + 8'(k), 1'b1);
            if (gaps) idle(1);
        end
    endtask

    // Monitor: pop-and-compare on every window, hold check on idle cycles.
    always @(negedge clk) begin
        if (!resetn) begin
            last_data = '0;
        end else if (window_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_window: got %h expected none", window_data);
            end else begin
                m_e = exp_q.pop_front();
                chk("window_data", window_data, m_e.data);
                chk("frame_end", 72'(frame_end), 72'(m_e.fe));
                chk("latency_cycle", 72'(cyc), 72'(m_e.cyc));
            end
            last_data = window_data;
        end else if (!acc_q) begin
            chk("hold_data", window_data, last_data);
            chk("idle_frame_end", 72'(frame_end), 72'(0));
        end
    end

    initial begin
        idle(3);
        chk("rst_window_valid", 72'(window_valid), 72'(0));
        chk("rst_frame_end", 72'(frame_end), 72'(0));
        chk("rst_window_data", window_data, 72'(0));
        resetn = 1'b1;

        // Continuous frame, then the same frame with a gap after every pixel.
        send_frame(8'd1, 1'b0);
        send_frame(8'd1, 1'b1);

        // Back-to-back frames with distinct contents.
        send_frame(8'd1, 1'b0);
        send_frame(8'd101, 1'b0);
        idle(3);

        // Reset while a window is on the outputs.
        for (int k = 1; k <= 10; k++) send(8'(k), 1'b1);
        send(8'd11, 1'b0);
        chk("pre_rst_window_valid", 72'(window_valid), 72'(1));
        #1;
        resetn = 1'b0;
        tb_r   = 0;
        tb_c   = 0;
        #1;
        chk("async_rst_window_valid", 72'(window_valid), 72'(0));
        chk("async_rst_frame_end", 72'(frame_end), 72'(0));
        chk("async_rst_window_data", window_data, 72'(0));
        idle(2);
        resetn = 1'b1;

        // Abandon a frame after pixel 7, then a clean frame.
        for (int k = 1; k <= 7; k++) send(8'(k), 1'b1);
        idle(1);
        resetn = 1'b0;
        tb_r   = 0;
        tb_c   = 0;
        idle(2);
        resetn = 1'b1;
        send_frame(8'd1, 1'b0);

        idle(4);
        chk("pending_windows", 72'(exp_q.size()), 72'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
